// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, state encodings and control codes for multicycle_ctrl (CTRL_IMM_EN)
package mc_pkg;

   // Instruction opcodes (IR[31:26])
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // ALU operation codes
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_ADDI  = 2'b11;

   // ALU B operand selects
   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source selects
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // State encodings; the immediate states keep their codes even when compiled out
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IMM_EXEC = 4'd10,
      S_IMM_WB   = 4'd11
   } state_t;

   // Full set of control lines driven towards the datapath
   typedef struct packed {
      logic       ir_write;
      logic       rega_load;
      logic       regb_load;
      logic       mdr_load;
      logic       aluout_load;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       pc_en;
      logic [1:0] pc_src;
   } ctrl_t;

   // Opcode to post-DECODE state; undecoded opcodes return S_FETCH
   function automatic state_t decode_target(input logic [5:0] op);
      state_t nxt;
      nxt = S_FETCH;
      case (op)
         OP_LW, OP_SW: nxt = S_MEM_ADDR;
         OP_R:         nxt = S_R_EXEC;
         OP_BEQ:       nxt = S_BRANCH;
         OP_J:         nxt = S_JUMP;
`ifdef CTRL_IMM_EN
         OP_ADDI:      nxt = S_IMM_EXEC;
`endif
         default:      nxt = S_FETCH;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state-to-control decoder (CTRL_IMM_EN)
import mc_pkg::*;

module mc_ctrl_decode (
   input  state_t cur_state,
   input  logic   mem_ready,
   input  logic   zero,
   output ctrl_t  ctrl
);

   // Moore decode: outputs follow the state, qualified only by mem_ready and zero
   always_comb begin
      ctrl = '0;
      case (cur_state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_en     = mem_ready;
         end
         S_DECODE: begin
            ctrl.rega_load   = 1'b1;
            ctrl.regb_load   = 1'b1;
            ctrl.aluout_load = 1'b1;
            ctrl.alu_src_b   = SRCB_IMM_SH2;
            ctrl.alu_op      = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_IMM;
            ctrl.alu_op      = ALU_ADD;
            ctrl.aluout_load = 1'b1;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
            ctrl.mdr_load = mem_ready;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_R_EXEC: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_REGB;
            ctrl.alu_op      = ALU_FUNCT;
            ctrl.aluout_load = 1'b1;
         end
         S_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REGB;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PC_ALUOUT;
            ctrl.pc_en     = zero;
         end
         S_JUMP: begin
            ctrl.pc_src = PC_JUMP;
            ctrl.pc_en  = 1'b1;
         end
`ifdef CTRL_IMM_EN
         S_IMM_EXEC: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRCB_IMM;
            ctrl.alu_op      = ALU_ADDI;
            ctrl.aluout_load = 1'b1;
         end
         S_IMM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
         end
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle datapath control FSM (CTRL_IMM_EN enables ADDI states)
import mc_pkg::*;

module multicycle_ctrl #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               ir_write,
   output logic               rega_load,
   output logic               regb_load,
   output logic               mdr_load,
   output logic               aluout_load,
   output logic               mem_read,
   output logic               mem_write,
   output logic               iord,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               pc_en,
   output logic [1:0]         pc_src,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   state_t cur_state;
   state_t state_nxt;
   logic   illegal_q;
   logic   illegal_nxt;
   ctrl_t  dec_ctrl;
   ctrl_t  out_ctrl;

   // An undecoded opcode in DECODE is flagged for the following cycle only
   assign illegal_nxt = (cur_state == S_DECODE) && (decode_target(opcode) == S_FETCH);

   // State register and illegal pulse flag; reset abandons any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         cur_state <= state_nxt;
         illegal_q <= illegal_nxt;
      end
   end

   // Next-state: memory states hold until mem_ready, unused encodings fall back to FETCH
   always_comb begin
      state_nxt = S_FETCH;
      case (cur_state)
         S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   state_nxt = decode_target(opcode);
         S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:   state_nxt = S_FETCH;
         S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   state_nxt = S_R_WB;
         S_R_WB:     state_nxt = S_FETCH;
         S_BRANCH:   state_nxt = S_FETCH;
         S_JUMP:     state_nxt = S_FETCH;
`ifdef CTRL_IMM_EN
         S_IMM_EXEC: state_nxt = S_IMM_WB;
         S_IMM_WB:   state_nxt = S_FETCH;
`endif
         default:    state_nxt = S_FETCH;
      endcase
   end

   mc_ctrl_decode u_decode (
      .cur_state (cur_state),
      .mem_ready (mem_ready),
      .zero      (zero),
      .ctrl      (dec_ctrl)
   );

   // Outputs: everything is forced low while reset is held, so no strobe survives the reset edge
   always_comb begin
      out_ctrl = '0;
      if (rst_n) begin
         out_ctrl = dec_ctrl;
      end
   end

   assign ir_write    = out_ctrl.ir_write;
   assign rega_load   = out_ctrl.rega_load;
   assign regb_load   = out_ctrl.regb_load;
   assign mdr_load    = out_ctrl.mdr_load;
   assign aluout_load = out_ctrl.aluout_load;
   assign mem_read    = out_ctrl.mem_read;
   assign mem_write   = out_ctrl.mem_write;
   assign iord        = out_ctrl.iord;
   assign reg_write   = out_ctrl.reg_write;
   assign reg_dst     = out_ctrl.reg_dst;
   assign mem_to_reg  = out_ctrl.mem_to_reg;
   assign alu_src_a   = out_ctrl.alu_src_a;
   assign alu_src_b   = out_ctrl.alu_src_b;
   assign alu_op      = out_ctrl.alu_op;
   assign pc_en       = out_ctrl.pc_en;
   assign pc_src      = out_ctrl.pc_src;
   assign illegal     = rst_n & illegal_q;
   assign state       = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven and randomized checks of multicycle_ctrl (CTRL_IMM_EN)
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       ir_write, rega_load, regb_load, mdr_load, aluout_load;
   logic       mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic       pc_en, illegal;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .ir_write(ir_write), .rega_load(rega_load), .regb_load(regb_load),
      .mdr_load(mdr_load), .aluout_load(aluout_load), .mem_read(mem_read),
      .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_en(pc_en), .pc_src(pc_src), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

   typedef struct {
      logic        rn;
      logic [5:0]  op;
      logic        z;
      logic        rdy;
      logic [3:0]  st;
      logic [19:0] exp;
   } row_t;

   row_t rows[$];

   // {ir,ra,rb,mdr,ao,mr,mw,iord,rw,rd,m2r,asa,asb,aop,pce,pcs,ill}
   function automatic logic [19:0] mk(input logic ir, ra, rb, mdr, ao, mr, mw, io, rw, rd, m2r, asa,
                                      input logic [1:0] asb, aop, input logic pce,
                                      input logic [1:0] pcs, input logic ill);
      return {ir, ra, rb, mdr, ao, mr, mw, io, rw, rd, m2r, asa, asb, aop, pce, pcs, ill};
   endfunction

   task automatic add(input logic rn, input logic [5:0] op, input logic z, input logic rdy,
                      input logic [3:0] st, input logic [19:0] e);
      row_t r;
      r.rn = rn; r.op = op; r.z = z; r.rdy = rdy; r.st = st; r.exp = e;
      rows.push_back(r);
   endtask

   task automatic check(input string name, input int idx, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0d: got %h want %h", name, idx, act, exp);
      end
   endtask

   function automatic logic [19:0] dut_vec();
      return {ir_write, rega_load, regb_load, mdr_load, aluout_load, mem_read, mem_write, iord,
              reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_en, pc_src, illegal};
   endfunction

   // Reference model step kinds
   localparam int K_FETCH = 0, K_DEC = 1, K_EXEC = 2, K_RD = 3, K_WR = 4, K_WB = 5, K_BR = 6, K_J = 7;

   typedef struct {
      int code;
      int kind;
   } step_t;

   function automatic bit op_legal(input logic [5:0] op);
`ifdef CTRL_IMM_EN
      return op inside {R, LW, SW, BEQ, JMP, ADDI};
`else
      return op inside {R, LW, SW, BEQ, JMP};
`endif
   endfunction

   initial begin
      logic [19:0] e_zero, e_f_rdy, e_f_wait, e_f_ill, e_dec, e_maddr, e_rd_rdy, e_rd_wait;
      logic [19:0] e_mwb, e_mwr, e_rex, e_rwb, e_br1, e_br0, e_jmp, e_iex, e_iwb;
      step_t steps[$];
      logic [5:0] op;
      bit   ill_prev, ill_this, first, done, rdy;
      int   cycles, stalls, base;
      logic [4:0] exp_s, act_s;

      e_zero    = '0;
      e_f_rdy   = mk(1,0,0,0,0, 1,0,0, 0,0,0, 0, 2'b01, 2'b00, 1, 2'b00, 0);
      e_f_wait  = mk(0,0,0,0,0, 1,0,0, 0,0,0, 0, 2'b01, 2'b00, 0, 2'b00, 0);
      e_f_ill   = mk(1,0,0,0,0, 1,0,0, 0,0,0, 0, 2'b01, 2'b00, 1, 2'b00, 1);
      e_dec     = mk(0,1,1,0,1, 0,0,0, 0,0,0, 0, 2'b11, 2'b00, 0, 2'b00, 0);
      e_maddr   = mk(0,0,0,0,1, 0,0,0, 0,0,0, 1, 2'b10, 2'b00, 0, 2'b00, 0);
      e_rd_rdy  = mk(0,0,0,1,0, 1,0,1, 0,0,0, 0, 2'b00, 2'b00, 0, 2'b00, 0);
      e_rd_wait = mk(0,0,0,0,0, 1,0,1, 0,0,0, 0, 2'b00, 2'b00, 0, 2'b00, 0);
      e_mwb     = mk(0,0,0,0,0, 0,0,0, 1,0,1, 0, 2'b00, 2'b00, 0, 2'b00, 0);
      e_mwr     = mk(0,0,0,0,0, 0,1,1, 0,0,0, 0, 2'b00, 2'b00, 0, 2'b00, 0);
      e_rex     = mk(0,0,0,0,1, 0,0,0, 0,0,0, 1, 2'b00, 2'b10, 0, 2'b00, 0);
      e_rwb     = mk(0,0,0,0,0, 0,0,0, 1,1,0, 0, 2'b00, 2'b00, 0, 2'b00, 0);
      e_br1     = mk(0,0,0,0,0, 0,0,0, 0,0,0, 1, 2'b00, 2'b01, 1, 2'b01, 0);
      e_br0     = mk(0,0,0,0,0, 0,0,0, 0,0,0, 1, 2'b00, 2'b01, 0, 2'b01, 0);
      e_jmp     = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0, 2'b00, 2'b00, 1, 2'b10, 0);
      e_iex     = mk(0,0,0,0,1, 0,0,0, 0,0,0, 1, 2'b10, 2'b11, 0, 2'b00, 0);
      e_iwb     = mk(0,0,0,0,0, 0,0,0, 1,0,0, 0, 2'b00, 2'b00, 0, 2'b00, 0);

      // reset, then R
      add(0, R, 0, 1, 0, e_zero);
      add(1, R, 0, 1, 0, e_f_rdy);
      add(1, R, 0, 1, 1, e_dec);
      add(1, R, 0, 1, 6, e_rex);
      add(1, R, 0, 1, 7, e_rwb);
      // LW with two wait cycles in MEM_RD
      add(1, LW, 0, 1, 0, e_f_rdy);
      add(1, LW, 0, 1, 1, e_dec);
      add(1, LW, 0, 1, 2, e_maddr);
      add(1, LW, 0, 0, 3, e_rd_wait);
      add(1, LW, 0, 0, 3, e_rd_wait);
      add(1, LW, 0, 1, 3, e_rd_rdy);
      add(1, LW, 0, 1, 4, e_mwb);
      // BEQ taken, then not taken
      add(1, BEQ, 1, 1, 0, e_f_rdy);
      add(1, BEQ, 1, 1, 1, e_dec);
      add(1, BEQ, 1, 1, 8, e_br1);
      add(1, BEQ, 0, 1, 0, e_f_rdy);
      add(1, BEQ, 0, 1, 1, e_dec);
      add(1, BEQ, 0, 1, 8, e_br0);
      // illegal opcode: pulse appears in the next FETCH only
      add(1, BAD, 0, 1, 0, e_f_rdy);
      add(1, BAD, 0, 1, 1, e_dec);
      add(1, SW, 0, 1, 0, e_f_ill);
      add(1, SW, 0, 1, 1, e_dec);
      add(1, SW, 0, 1, 2, e_maddr);
      add(1, SW, 0, 0, 5, e_mwr);
      // reset dropped mid store, then released with memory busy
      add(0, SW, 0, 0, 0, e_zero);
      add(1, SW, 0, 0, 0, e_f_wait);
      add(1, JMP, 0, 1, 0, e_f_rdy);
      add(1, JMP, 0, 1, 1, e_dec);
      add(1, JMP, 0, 1, 9, e_jmp);
      add(1, ADDI, 0, 1, 0, e_f_rdy);
      add(1, ADDI, 0, 1, 1, e_dec);
`ifdef CTRL_IMM_EN
      add(1, ADDI, 0, 1, 10, e_iex);
      add(1, ADDI, 0, 1, 11, e_iwb);
      add(1, R, 0, 1, 0, e_f_rdy);
`else
      add(1, R, 0, 1, 0, e_f_ill);
      add(1, R, 0, 1, 1, e_dec);
`endif

      foreach (rows[i]) begin
         @(negedge clk);
         rst_n = rows[i].rn; opcode = rows[i].op; zero = rows[i].z; mem_ready = rows[i].rdy;
         #1;
         check("tbl_state", i, {16'd0, state}, {16'd0, rows[i].st});
         check("tbl_outputs", i, dut_vec(), rows[i].exp);
      end

      // Randomized instruction stream against the instruction-level model
      @(negedge clk); rst_n = 1'b0; mem_ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      ill_prev = 1'b0;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 6))
            0: op = R;
            1: op = LW;
            2: op = SW;
            3: op = BEQ;
            4: op = JMP;
            5: op = ADDI;
            default: begin
               op = 6'($urandom_range(0, 63));
               while (op_legal(op)) op = 6'($urandom_range(0, 63));
            end
         endcase
         steps = {};
         steps.push_back('{0, K_FETCH});
         steps.push_back('{1, K_DEC});
         ill_this = 1'b0;
         base = 2;
         if (op == LW)       begin steps.push_back('{2, K_EXEC}); steps.push_back('{3, K_RD}); steps.push_back('{4, K_WB}); base = 5; end
         else if (op == SW)  begin steps.push_back('{2, K_EXEC}); steps.push_back('{5, K_WR}); base = 4; end
         else if (op == R)   begin steps.push_back('{6, K_EXEC}); steps.push_back('{7, K_WB}); base = 4; end
         else if (op == BEQ) begin steps.push_back('{8, K_BR}); base = 3; end
         else if (op == JMP) begin steps.push_back('{9, K_J}); base = 3; end
         else if (op_legal(op)) begin steps.push_back('{10, K_EXEC}); steps.push_back('{11, K_WB}); base = 4; end
         else ill_this = 1'b1;

         cycles = 0;
         stalls = 0;
         foreach (steps[s]) begin
            first = 1'b1;
            done = 1'b0;
            while (!done) begin
               @(negedge clk);
               if (cycles == 0) opcode = op;
               rdy = ($urandom_range(0, 3) != 0);
               mem_ready = rdy;
               zero = 1'($urandom_range(0, 1));
               #1;
               exp_s[4] = (steps[s].kind == K_FETCH) || (steps[s].kind == K_RD);
               exp_s[3] = (steps[s].kind == K_WR);
               exp_s[2] = (steps[s].kind == K_WB);
               exp_s[1] = (steps[s].kind == K_FETCH && rdy) || (steps[s].kind == K_BR && zero) ||
                          (steps[s].kind == K_J);
               exp_s[0] = (steps[s].kind == K_FETCH) && first && ill_prev;
               act_s = {mem_read, mem_write, reg_write, pc_en, illegal};
               check("rnd_state", n, {16'd0, state}, {16'd0, 4'(steps[s].code)});
               check("rnd_strobes", n, {15'd0, act_s}, {15'd0, exp_s});
               cycles++;
               first = 1'b0;
               if ((steps[s].kind == K_FETCH || steps[s].kind == K_RD || steps[s].kind == K_WR) && !rdy)
                  stalls++;
               else
                  done = 1'b1;
               if (cycles > 200) begin
                  check("rnd_cycle_bound", n, 20'(cycles), 20'd200);
                  done = 1'b1;
               end
            end
            if (steps[s].kind == K_FETCH) ill_prev = 1'b0;
         end
         check("rnd_latency", n, 20'(cycles), 20'(base + stalls));
         ill_prev = ill_this;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM for the multicycle 32-bit datapath. It sequences instruction fetch, decode, execute, memory and write-back by driving the load enables of RegA, RegB, IR, MDR and ALUOut, plus the mux selects and write strobes. It stalls on a memory ready handshake. It sits beside the datapath and only reads back opcode and the ALU zero flag.

## Interface
- STATE_W, 4, state register width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- ir_write, rega_load, regb_load, mdr_load, aluout_load  out  1 each  register load enables
- mem_read, mem_write  out  1 each  memory strobes, held until mem_ready
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- reg_write  out  1  register-file write
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = RegA
- alu_src_b  out  2  ALU B select: 00 = RegB, 01 = 4, 10 = signext imm, 11 = signext imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = add (immediate)
- pc_en  out  1  PC load
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  out  1  one-cycle pulse on an undecoded opcode
- state  out  STATE_W  current state, debug

## Operation
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11. Encodings 12–15 are unreachable and recover to FETCH.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en assert only in the cycle where mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE:
  - Drives rega_load=1, regb_load=1, aluout_load=1, alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: LW/SW → MEM_ADDR; R → R_EXEC; BEQ → BRANCH; J → JUMP; ADDI → IMM_EXEC.
  - Any other opcode → FETCH, with illegal pulsed for one cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, aluout_load=1. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, iord=1. mdr_load is asserted in the mem_ready cycle, then the FSM moves to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEM_WR: mem_write=1, iord=1. On mem_ready the FSM moves to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, aluout_load=1. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next state FETCH.
- JUMP: pc_src=10, pc_en=1. Next state FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, aluout_load=1. Next state IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- Every output not listed for a state is 0.

## Timing
- Reset:
  - rst_n low forces state=FETCH immediately.
  - While rst_n is low, every output is 0, including mem_read and illegal.
  - The first FETCH read is issued in the first cycle after rst_n rises.
- Reset mid-operation abandons the instruction. No write strobe may assert during or after the reset edge until a new FETCH completes.
- Latency with mem_ready always 1:
  - R: 4 cycles. LW: 5. SW: 4. BEQ: 3. J: 3. ADDI: 4.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Handshake:
  - mem_read/mem_write stay high and iord stays stable until mem_ready is sampled high.
  - mem_ready is ignored in every other state.
- pc_en in BRANCH is combinational from zero. All other outputs depend only on state and mem_ready.

## Configuration
- CTRL_IMM_EN:
  - Defined: IMM_EXEC/IMM_WB exist and ADDI decodes normally.
  - Undefined: both states are removed and opcode 001000 is treated as illegal (DECODE → FETCH, illegal pulse).
  - Both builds keep the same encodings for every other state.

## Structure
- Shared package `mc_pkg` holds:
  - opcode constants
  - state encodings
  - alu_op / alu_src_b / pc_src codes
- Optional sub-module `mc_ctrl_decode`: combinational state-to-outputs decoder. The FSM next-state logic and state register stay in `multicycle_ctrl`.

## Test plan
- Reset, then R opcode with mem_ready=1:
  - state sequence 0,1,6,7,0
  - reg_write=1, reg_dst=1 only in cycle 4
  - pc_en=1 only in cycle 1
- LW with mem_ready low for 2 cycles in MEM_RD: sequence 0,1,2,3,3,3,4,0; mdr_load=1 only in the third MEM_RD cycle.
- BEQ with zero=1, then BEQ with zero=0: pc_en=1 and pc_src=01 in BRANCH for the first, pc_en=0 for the second; each takes 3 cycles.
- Opcode 111111: DECODE → FETCH, illegal=1 for exactly one cycle, no reg_write or mem_write.
- rst_n dropped during MEM_WR with mem_ready=0: mem_write falls immediately; after release, state=0 and mem_read=1.
- Build without CTRL_IMM_EN, opcode 001000: illegal pulse. With the macro: sequence 0,1,10,11,0, and alu_op=11 in IMM_EXEC.
